// File: rtl/m_timer_pkg.sv
// Shared definitions for the m_timer block: FSM states, register
// indices decoded from addr[3:2], CTRL field positions and mode codes.
package m_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    // Register indices, taken from addr[3:2]
    localparam logic [1:0] IDX_CTRL   = 2'd0;
    localparam logic [1:0] IDX_PRESET = 2'd1;
    localparam logic [1:0] IDX_COUNT  = 2'd2;
    localparam logic [1:0] IDX_NONE   = 2'd3;

    // CTRL mode field codes; 1x behaves like one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // CTRL bit positions
    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_IM   = 3;

    // Only the exact 01 code selects auto-reload.
    function automatic logic is_reload(input logic [1:0] mode);
        return mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/m_timer.sv
// m_timer: memory-mapped down-counter with one-shot and auto-reload
// modes. The bridge strips the base address; only addr[3:2] is decoded.
// Register and FSM next values are computed in one combinational block
// so that a CPU CTRL write always overrides the FSM in the same cycle.
module m_timer
    import m_timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    state_e      r_state;
    state_e      w_next_state;
    logic [3:0]  r_ctrl;
    logic [3:0]  w_next_ctrl;
    logic [31:0] r_preset;
    logic [31:0] w_next_preset;
    logic [31:0] r_count;
    logic [31:0] w_next_count;
    logic        r_irq_flag;
    logic        w_next_irq_flag;

    logic [1:0]  w_idx;
    logic        w_enable;
    logic        w_reload;
    logic        w_wr_ctrl;
    logic        w_wr_preset;

    // Address bits outside the register index are deliberately ignored.
    logic        w_unused_addr;
    assign w_unused_addr = ^{addr[31:4], addr[1:0]};

    assign w_idx       = addr[3:2];
    assign w_enable    = r_ctrl[CTRL_EN];
    assign w_reload    = is_reload(r_ctrl[CTRL_MODE +: 2]);
    assign w_wr_ctrl   = we && (w_idx == IDX_CTRL);
    assign w_wr_preset = we && (w_idx == IDX_PRESET);

    // State and register update; synchronous active-low reset wins over all
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values computed by the combinational block.
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_ctrl     <= '0;
            r_preset   <= '0;
            r_count    <= '0;
            r_irq_flag <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_ctrl     <= w_next_ctrl;
            r_preset   <= w_next_preset;
            r_count    <= w_next_count;
            r_irq_flag <= w_next_irq_flag;
        end
    end

    // FSM next-state and register next values; CPU writes applied last
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        w_next_state    = r_state;
        w_next_ctrl     = r_ctrl;
        w_next_preset   = r_preset;
        w_next_count    = r_count;
        w_next_irq_flag = r_irq_flag;

        case (r_state)
            ST_IDLE: begin
                if (w_enable) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_next_count = r_preset;
                w_next_state = ST_CNT;
            end
            ST_CNT: begin
                if (!w_enable) begin
                    w_next_state = ST_IDLE;
                end else if (r_count > 32'd1) begin
                    w_next_count = r_count - 32'd1;
                end else begin
                    // Terminal count for 0 and 1 alike: never wraps
                    w_next_count    = '0;
                    w_next_irq_flag = 1'b1;
                    w_next_state    = ST_INT;
                end
            end
            ST_INT: begin
                if (w_reload) begin
                    w_next_irq_flag = 1'b0;
                    w_next_state    = ST_LOAD;
                end else begin
                    w_next_ctrl[CTRL_EN] = 1'b0;
                    w_next_state         = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        // A CTRL write replaces whatever the FSM did to CTRL this cycle
        if (w_wr_ctrl) begin
            w_next_ctrl     = din[3:0];
            w_next_irq_flag = 1'b0;
        end
        if (w_wr_preset) begin
            w_next_preset = din;
        end
    end

    // Read mux, same-cycle from addr[3:2]
    always_comb begin
        dout = '0;
        case (w_idx)
            IDX_CTRL:   dout = {28'b0, r_ctrl};
            IDX_PRESET: dout = r_preset;
            IDX_COUNT:  dout = r_count;
            IDX_NONE:   dout = '0;
            default:    dout = '0;
        endcase
    end

    assign irq = r_irq_flag & r_ctrl[CTRL_IM];

endmodule

// File: tb/tb_m_timer.sv
// Directed testbench for m_timer. Inputs change and outputs are sampled
// 1 ns or more after each rising edge; expected values are hand-derived.
module tb_m_timer;
    import m_timer_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int total = 0;
    int bad   = 0;

    m_timer dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle register write
    task automatic wr(input logic [1:0] idx, input logic [31:0] data);
        addr = 32'h0000_7f00 | {28'b0, idx, 2'b00};
        din  = data;
        we   = 1'b1;
        tick();
        we   = 1'b0;
        din  = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] idx, input logic [31:0] exp);
        addr = 32'h0000_7f10 | {28'b0, idx, 2'b00};
        #1;
        check(tag, dout, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check(tag, {31'b0, irq}, {31'b0, exp});
    endtask

    initial begin
        addr  = '0;
        din   = '0;
        we    = 1'b0;
        reset = 1'b0;

        // Reset for two cycles with a concurrent CTRL write that must lose
        addr = 32'h0000_7f00;
        din  = 32'h0000_000f;
        we   = 1'b1;
        tick();
        tick();
        we    = 1'b0;
        din   = '0;
        reset = 1'b1;
        chk_reg("rst_ctrl", IDX_CTRL, 32'h0);
        chk_reg("rst_preset", IDX_PRESET, 32'h0);
        chk_reg("rst_count", IDX_COUNT, 32'h0);
        chk_irq("rst_irq", 1'b0);

        // One-shot, PRESET=5; upper CTRL write bits discarded
        wr(IDX_PRESET, 32'd5);
        wr(IDX_CTRL, 32'habcd_0009);
        chk_reg("os_ctrl_wr", IDX_CTRL, 32'h9);
        tick();                                   // LOAD
        tick();                                   // CNT, count=5
        chk_reg("os_count5", IDX_COUNT, 32'd5);
        for (int i = 4; i >= 1; i--) begin
            tick();
            chk_reg("os_count_dec", IDX_COUNT, 32'(i));
            chk_irq("os_irq_low", 1'b0);
        end
        tick();                                   // INT
        chk_reg("os_count0", IDX_COUNT, 32'd0);
        chk_irq("os_irq_rise", 1'b1);
        tick();                                   // IDLE, enable cleared
        chk_reg("os_ctrl_after", IDX_CTRL, 32'h8);
        chk_irq("os_irq_held", 1'b1);
        tick();
        chk_irq("os_irq_held2", 1'b1);
        chk_reg("os_count_stays0", IDX_COUNT, 32'd0);

        // CTRL write clears the held flag on the next edge
        wr(IDX_CTRL, 32'h8);
        chk_irq("clr_irq", 1'b0);

        // Auto-reload, PRESET=3: one-cycle pulse every 5 cycles
        wr(IDX_PRESET, 32'd3);
        wr(IDX_CTRL, 32'hb);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                chk_irq("ar_irq_low", 1'b0);
            end
            tick();
            chk_irq("ar_irq_pulse", 1'b1);
        end
        chk_reg("ar_ctrl_kept", IDX_CTRL, 32'hb);
        // Stop from INT: goes LOAD, CNT, then IDLE with COUNT held
        wr(IDX_CTRL, 32'h0);
        chk_irq("ar_stop_irq", 1'b0);
        tick();
        tick();
        chk_reg("ar_count_held", IDX_COUNT, 32'd3);
        tick();
        chk_reg("ar_count_held2", IDX_COUNT, 32'd3);

        // PRESET=0: irq three cycles after the CTRL write, no wrap
        wr(IDX_PRESET, 32'd0);
        wr(IDX_CTRL, 32'h9);
        tick();
        chk_irq("p0_irq_c1", 1'b0);
        tick();
        chk_reg("p0_count_cnt", IDX_COUNT, 32'd0);
        chk_irq("p0_irq_c2", 1'b0);
        tick();
        chk_reg("p0_count_int", IDX_COUNT, 32'd0);
        chk_irq("p0_irq_c3", 1'b1);

        // CTRL write during INT beats the FSM clearing enable; mode 10 acts one-shot
        wr(IDX_CTRL, 32'hd);
        chk_reg("race_ctrl", IDX_CTRL, 32'hd);
        chk_irq("race_irq_clr", 1'b0);
        tick();
        tick();
        tick();
        chk_irq("m10_irq", 1'b1);
        tick();
        chk_reg("m10_ctrl_after", IDX_CTRL, 32'hc);

        // IM=0 run: flag sets internally but irq stays low
        wr(IDX_CTRL, 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_irq("im0_irq", 1'b0);
        end
        tick();
        chk_reg("im0_ctrl_after", IDX_CTRL, 32'h0);
        chk_irq("im0_irq_end", 1'b0);

        // PRESET=1 reaches INT on its first CNT cycle
        wr(IDX_PRESET, 32'd1);
        wr(IDX_CTRL, 32'h9);
        tick();
        tick();
        chk_reg("p1_count", IDX_COUNT, 32'd1);
        chk_irq("p1_irq_low", 1'b0);
        tick();
        chk_reg("p1_count0", IDX_COUNT, 32'd0);
        chk_irq("p1_irq", 1'b1);
        wr(IDX_CTRL, 32'h8);
        chk_irq("p1_irq_clr", 1'b0);

        // Long count: PRESET and COUNT writes do not disturb the run
        wr(IDX_PRESET, 32'd100);
        wr(IDX_CTRL, 32'h9);
        tick();
        tick();
        chk_reg("long_count100", IDX_COUNT, 32'd100);
        wr(IDX_PRESET, 32'd50);
        chk_reg("long_count99", IDX_COUNT, 32'd99);
        chk_reg("long_preset50", IDX_PRESET, 32'd50);
        wr(IDX_COUNT, 32'h1234);
        chk_reg("long_count_wr_ign", IDX_COUNT, 32'd98);
        wr(IDX_NONE, 32'hffff_ffff);
        chk_reg("long_count97", IDX_COUNT, 32'd97);
        chk_reg("idx3_reads0", IDX_NONE, 32'h0);

        // One-cycle reset mid-count
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk_reg("mid_rst_ctrl", IDX_CTRL, 32'h0);
        chk_reg("mid_rst_preset", IDX_PRESET, 32'h0);
        chk_reg("mid_rst_count", IDX_COUNT, 32'h0);
        chk_irq("mid_rst_irq", 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_irq("post_rst_irq", 1'b0);
        end
        wr(IDX_COUNT, 32'h1234);
        chk_reg("post_rst_count_wr", IDX_COUNT, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m_timer.md
M_TIMER -- requirements
Module: m_timer

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-003 SHALL have port addr, input, 32 bits: byte address; only addr[3:2] decoded (0=CTRL at 0x7f00/0x7f10 base+0, 1=PRESET +4, 2=COUNT +8, 3=unused).
REQ-004 SHALL have port we, input, 1 bit: word write strobe from MEM stage, already qualified by bridge select and no exception.
REQ-005 SHALL have port din, input, 32 bits: store data.
REQ-006 SHALL have port dout, output, 32 bits: read data returned to the load data-processing stage as dm_temp.
REQ-007 SHALL have port irq, output, 1 bit: interrupt request to CP0 HWInt.

Function
REQ-008 SHALL present dout combinationally from addr[3:2] in the same cycle: CTRL = {28'b0, ctrl[3:0]}, PRESET, COUNT; index 3 returns 0.
REQ-009 SHALL decode CTRL bits: [0] enable, [2:1] mode (00 = one-shot, 01 = auto-reload, 1x treated as 00), [3] IM interrupt mask.
REQ-010 SHALL on we with index 0 store din[3:0] into CTRL and clear the internal irq flag; din[31:4] discarded.
REQ-011 SHALL on we with index 1 store din into PRESET; a running count is unaffected until the next LOAD.
REQ-012 SHALL ignore writes to COUNT (index 2) and index 3.
REQ-013 SHALL run a 4-state FSM: IDLE, LOAD, CNT, INT.
REQ-014 IDLE: if enable=1 go LOAD next cycle, else stay.
REQ-015 LOAD: COUNT <= PRESET; go CNT.
REQ-016 CNT: if enable=0 go IDLE with COUNT held; else if COUNT > 1 decrement by 1; else COUNT <= 0, irq flag <= 1, go INT.
REQ-017 INT, mode 00: enable <= 0, go IDLE; irq flag stays set until a CTRL write or reset.
REQ-018 INT, mode 01: irq flag <= 0, go LOAD; irq thus pulses exactly one cycle per period.
REQ-019 SHALL drive irq = irq flag AND IM, combinationally.
REQ-020 PRESET = 0 or 1 SHALL both reach INT on the first CNT cycle (no underflow, COUNT never wraps to 0xffffffff).
REQ-021 A CPU CTRL write in the same cycle as an FSM update of enable SHALL win (written value takes effect).
REQ-022 A CTRL write clearing enable while in LOAD or INT SHALL return FSM to IDLE on the following cycle from CNT; FSM still completes the current state's actions except per REQ-021.
REQ-023 Period in mode 01 with PRESET = N >= 1 SHALL be N+2 cycles between irq pulses.

Reset
REQ-024 On reset = 0 at a rising edge: CTRL, PRESET, COUNT = 0, irq flag = 0, FSM = IDLE; reset SHALL override any concurrent we.
REQ-025 Reset asserted mid-count SHALL abort counting with no irq pulse emitted that cycle or after.
REQ-026 dout SHALL read 0 for all indices after reset; irq SHALL be 0.

Structure
REQ-027 FSM state encodings, register offsets (CTRL/PRESET/COUNT indices) and mode codes SHALL be defined in const.v next to the dp_* codes.
REQ-028 Timer base ranges (0x7f00-0x7f0b, 0x7f10-0x7f1b) SHALL stay in the bridge; m_timer sees only offsets.
REQ-029 Single module, no sub-module; two instances (TC1, TC2) are placed by the bridge.

Verification
REQ-030 Reset low 2 cycles then high -> dout = 0 at indices 0,1,2; irq = 0.
REQ-031 Write PRESET=5, CTRL=0x9 (enable, mode 00, IM) -> COUNT reads 5,4,3,2,1,0; irq rises on cycle entering INT and stays 1; CTRL reads 0x8 afterwards.
REQ-032 PRESET=3, CTRL=0xB (mode 01, IM) -> irq one-cycle pulses every 5 cycles; CTRL stays 0xB.
REQ-033 PRESET=0, CTRL=0x9 -> irq set after IDLE, LOAD, CNT (3 cycles after write); COUNT reads 0, never 0xffffffff.
REQ-034 Mode 00 irq held, then write CTRL=0x8 -> irq 0 next cycle; CTRL=0x1 (IM=0) run -> irq stays 0 though flag sets.
REQ-035 Mid-count (COUNT=100) assert reset one cycle -> all registers 0, FSM IDLE, no irq; write to COUNT (din=0x1234) -> COUNT unchanged.
